csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_pkg.sv | 49 ++++
 rtl/csr_if.sv | 33 +++
 rtl/csr_counter64.sv | 44 ++++
 rtl/csr_unit.sv | 159 +++++++++++++++
 tb/tb_csr_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR unit: data/address widths, the CSR address
// map, the default misa value, and the decoded write-strobe bundle used
// between the address decoder and the state registers.
// ---------------------------------------------------------------------------
package csr_pkg;

    localparam int unsigned CSR_AW = 12;
    localparam int unsigned CSR_DW = 32;

    // Default constant misa: MXL=1 (RV32), extensions I and M.
    localparam logic [31:0] MISA_DEFAULT = 32'h4000_1100;

    // Clock cycles per time tick when the time counter is built in.
    localparam int unsigned TIME_DIV_DEFAULT = 50;

    // Address 0 on the write port means "no write this cycle".
    localparam logic [11:0] CSR_NONE      = 12'h000;

    // User-level read-only counter aliases.
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_TIME      = 12'hC01;
    localparam logic [11:0] CSR_TIMEH     = 12'hC81;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // Machine-level writable counters and scratch register.
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;

    // Machine-level read-only identification.
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // One-hot write strobes produced by the write-address decoder.
    typedef struct packed {
        logic cycle_lo;
        logic cycle_hi;
        logic instret_lo;
        logic instret_hi;
        logic mscratch;
    } csr_wr_s;

endpackage : csr_pkg

// File: rtl/csr_if.sv
// ---------------------------------------------------------------------------
// csr_if
// Groups the CSR access bus of csr_unit: one write port, one combinational
// read port, and the retired-instruction strobe.
//   csrWAddr    write address (0 = no write)
//   csrWData    write data
//   csrRAddr    read address
//   csrRData    read data for csrRAddr
//   csrIllegal  csrRAddr is not an implemented CSR
//   csrInstStep one instruction retired this cycle
// master: the core side issuing accesses; slave: the CSR unit side.
// ---------------------------------------------------------------------------
interface csr_if;
    import csr_pkg::*;

    logic [CSR_AW-1:0] csrWAddr;
    logic [CSR_DW-1:0] csrWData;
    logic [CSR_AW-1:0] csrRAddr;
    logic [CSR_DW-1:0] csrRData;
    logic              csrIllegal;
    logic              csrInstStep;

    modport master (
        output csrWAddr, csrWData, csrRAddr, csrInstStep,
        input  csrRData, csrIllegal
    );

    modport slave (
        input  csrWAddr, csrWData, csrRAddr, csrInstStep,
        output csrRData, csrIllegal
    );

endinterface : csr_if

// File: rtl/csr_counter64.sv
// ---------------------------------------------------------------------------
// csr_counter64
// 64-bit counter with independently writable 32-bit halves.
//   clk_i     clock, all state changes on the rising edge
//   reset_i   synchronous active-high clear (beats writes and increments)
//   inc_i     add one this cycle
//   wrLo_i    load wrData_i into bits [31:0], upper half holds
//   wrHi_i    load wrData_i into bits [63:32], lower half holds
//   wrData_i  write data
//   value_o   current count
// A write always wins over a same-cycle increment; the increment is dropped.
// ---------------------------------------------------------------------------
module csr_counter64 (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inc_i,
    input  logic        wrLo_i,
    input  logic        wrHi_i,
    input  logic [31:0] wrData_i,
    output logic [63:0] value_o
);

    logic [63:0] r_value;

    // NOTE: reset is tested inside the clocked block, so it is synchronous and
    // takes effect on the next rising edge; a write in that cycle is lost.
    // NOTE: non-blocking assignments for every flop so all registers sample
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_value <= '0;
        end else if (wrLo_i) begin
            r_value[31:0] <= wrData_i;
        end else if (wrHi_i) begin
            r_value[63:32] <= wrData_i;
        end else if (inc_i) begin
            // Full 64-bit add carries lo into hi and wraps 2^64-1 -> 0.
            r_value <= r_value + 64'd1;
        end
    end

    assign value_o = r_value;

endmodule : csr_counter64

// File: rtl/csr_unit.sv
// ---------------------------------------------------------------------------
// csr_unit
// Small RV32 CSR block: cycle / instret (and optionally time) 64-bit
// counters, mscratch, and constant misa / mhartid.
//
// Parameters
//   TIME_DIV    clk_i cycles per time tick (1..65535)
//   MISA_VALUE  constant returned for misa
//
// Ports
//   clk_i          clock
//   reset_i        synchronous active-high reset
//   csrWAddr_i     write address, 12'h000 = no write
//   csrWData_i     write data
//   csrRAddr_i     read address
//   csrRData_o     read data (combinational from registered state)
//   csrIllegal_o   flags a read address that maps to no CSR
//   csrInstStep_i  one instruction retired this cycle
//
// Build option
//   CSR_TIME_EN  when defined, adds the time prescaler and the time counter
//                readable at C01/C81; otherwise those addresses are illegal.
//
// Reads see state before any same-cycle write (no write bypass).
// ---------------------------------------------------------------------------
module csr_unit
    import csr_pkg::*;
#(
    parameter int unsigned TIME_DIV   = TIME_DIV_DEFAULT,
    parameter logic [31:0] MISA_VALUE = MISA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [11:0] csrWAddr_i,
    input  logic [31:0] csrWData_i,
    input  logic [11:0] csrRAddr_i,
    output logic [31:0] csrRData_o,
    output logic        csrIllegal_o,
    input  logic        csrInstStep_i
);

    csr_wr_s     w_wr;
    logic [63:0] w_cycle;
    logic [63:0] w_instret;
    logic [31:0] r_mscratch;
    logic [31:0] w_rdata;
    logic        w_illegal;

    // -----------------------------------------------------------------------
    // Write decode. Read-only and unknown addresses (including the idle
    // address 0) decode to no strobe and so leave all state untouched.
    // -----------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        w_wr = '0;
        case (csrWAddr_i)
            CSR_MCYCLE:    w_wr.cycle_lo   = 1'b1;
            CSR_MCYCLEH:   w_wr.cycle_hi   = 1'b1;
            CSR_MINSTRET:  w_wr.instret_lo = 1'b1;
            CSR_MINSTRETH: w_wr.instret_hi = 1'b1;
            CSR_MSCRATCH:  w_wr.mscratch   = 1'b1;
            default:       w_wr = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Counters. cycle counts every non-reset cycle; reset priority inside
    // the counter suppresses the increment while reset_i is high.
    // -----------------------------------------------------------------------
    csr_counter64 u_cycle (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .inc_i    (1'b1),
        .wrLo_i   (w_wr.cycle_lo),
        .wrHi_i   (w_wr.cycle_hi),
        .wrData_i (csrWData_i),
        .value_o  (w_cycle)
    );

    csr_counter64 u_instret (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .inc_i    (csrInstStep_i),
        .wrLo_i   (w_wr.instret_lo),
        .wrHi_i   (w_wr.instret_hi),
        .wrData_i (csrWData_i),
        .value_o  (w_instret)
    );

`ifdef CSR_TIME_EN
    // Prescaler runs 0..TIME_DIV-1; time advances on the edge where the
    // prescaler wraps back to 0, i.e. once every TIME_DIV cycles.
    localparam logic [15:0] PRESC_MAX = 16'(TIME_DIV - 1);

    logic [15:0] r_presc;
    logic        w_time_tick;
    logic [63:0] w_time;

    assign w_time_tick = (r_presc == PRESC_MAX);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_presc <= '0;
        end else if (w_time_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    csr_counter64 u_time (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .inc_i    (w_time_tick),
        .wrLo_i   (1'b0),
        .wrHi_i   (1'b0),
        .wrData_i ('0),
        .value_o  (w_time)
    );
`endif

    // -----------------------------------------------------------------------
    // mscratch
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_mscratch <= '0;
        end else if (w_wr.mscratch) begin
            r_mscratch <= csrWData_i;
        end
    end

    // -----------------------------------------------------------------------
    // Read mux: zero-latency, sourced only from registered state.
    // -----------------------------------------------------------------------
    always_comb begin
        w_rdata   = '0;
        w_illegal = 1'b0;
        case (csrRAddr_i)
            CSR_CYCLE,    CSR_MCYCLE:    w_rdata = w_cycle[31:0];
            CSR_CYCLEH,   CSR_MCYCLEH:   w_rdata = w_cycle[63:32];
            CSR_INSTRET,  CSR_MINSTRET:  w_rdata = w_instret[31:0];
            CSR_INSTRETH, CSR_MINSTRETH: w_rdata = w_instret[63:32];
`ifdef CSR_TIME_EN
            CSR_TIME:                    w_rdata = w_time[31:0];
            CSR_TIMEH:                   w_rdata = w_time[63:32];
`endif
            CSR_MSCRATCH:                w_rdata = r_mscratch;
            CSR_MISA:                    w_rdata = MISA_VALUE;
            CSR_MHARTID:                 w_rdata = '0;
            default:                     w_illegal = 1'b1;
        endcase
    end

    assign csrRData_o   = w_rdata;
    assign csrIllegal_o = w_illegal;

endmodule : csr_unit

// File: tb/tb_csr_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_unit
// Directed bench for csr_unit. The stimulus process drives the bus and, for
// each read, pushes the hand-computed expected {data, illegal} into a
// scoreboard queue and pulses rd_strobe; an independent monitor pops and
// compares on every strobe. Inputs change 1 time unit after each rising
// edge; reads are sampled mid-cycle, well away from the clock edge.
// Built with TIME_DIV=4 so the time counter is exercised when CSR_TIME_EN
// is defined; without it C01/C81 are expected to read 0 / illegal.
// ---------------------------------------------------------------------------
module tb_csr_unit;
    import csr_pkg::*;

`ifdef CSR_TIME_EN
    localparam bit TIME_ON = 1'b1;
`else
    localparam bit TIME_ON = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
        logic        ill;
    } exp_t;

    logic clk;
    logic reset_i;
    logic rd_strobe;
    exp_t sb[$];
    int   n_tests;
    int   n_fail;

    csr_if bus ();

    csr_unit #(
        .TIME_DIV   (4),
        .MISA_VALUE (32'h4000_1100)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .csrWAddr_i    (bus.csrWAddr),
        .csrWData_i    (bus.csrWData),
        .csrRAddr_i    (bus.csrRAddr),
        .csrRData_o    (bus.csrRData),
        .csrIllegal_o  (bus.csrIllegal),
        .csrInstStep_i (bus.csrInstStep)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per read strobe.
    always @(posedge rd_strobe) begin
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("rd_%h_data", e.addr), bus.csrRData, e.data);
            check($sformatf("rd_%h_illegal", e.addr), {31'd0, bus.csrIllegal}, {31'd0, e.ill});
        end
    end

    // Advance n rising edges, then move 1 unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] d, input logic ill);
        bus.csrRAddr = a;
        sb.push_back('{addr: a, data: d, ill: ill});
        #1 rd_strobe = 1'b1;
        #1 rd_strobe = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.csrWAddr = a;
        bus.csrWData = d;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rd_strobe = 1'b0;
        reset_i = 1'b1;
        bus.csrWAddr = 12'h000;
        bus.csrWData = 32'h0;
        bus.csrRAddr = 12'h000;
        bus.csrInstStep = 1'b0;

        // Held in reset: counters stay 0, constants readable.
        tick(3);
        rd(12'hC00, 32'h0, 1'b0);
        rd(12'h340, 32'h0, 1'b0);
        rd(12'h301, 32'h4000_1100, 1'b0);
        rd(12'hF14, 32'h0, 1'b0);

        // Release; first edge after release gives cycle=1.
        reset_i = 1'b0;
        tick(10);
        rd(12'hC00, 32'd10, 1'b0);
        rd(12'hC80, 32'd0, 1'b0);
        rd(12'hC01, TIME_ON ? 32'd2 : 32'd0, !TIME_ON);
        tick(10);
        rd(12'hC00, 32'd20, 1'b0);
        rd(12'hC01, TIME_ON ? 32'd5 : 32'd0, !TIME_ON);
        rd(12'hC81, 32'd0, !TIME_ON);

        // Carry: hi=0 then lo=FFFF_FFFF; write edges suppress the increment.
        wr(12'hB80, 32'h0);
        tick(1);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hC00, 32'd20, 1'b0);          // old value, no bypass, lo held
        tick(1);
        wr(12'h000, 32'h0);
        rd(12'hC00, 32'hFFFF_FFFF, 1'b0);
        rd(12'hC80, 32'h0, 1'b0);
        tick(1);
        rd(12'hC00, 32'h0, 1'b0);
        rd(12'hC80, 32'h1, 1'b0);
        rd(12'hB80, 32'h1, 1'b0);

        // Collision: retire + write minstret in the same cycle.
        bus.csrInstStep = 1'b1;
        wr(12'hB02, 32'd5);
        tick(1);                            // cycle lo = 1
        wr(12'h000, 32'h0);
        rd(12'hC02, 32'd5, 1'b0);
        tick(1);                            // cycle lo = 2
        bus.csrInstStep = 1'b0;
        rd(12'hC02, 32'd6, 1'b0);
        rd(12'hB02, 32'd6, 1'b0);
        rd(12'hC82, 32'd0, 1'b0);
        wr(12'hB82, 32'd7);
        tick(1);                            // cycle lo = 3
        wr(12'h000, 32'h0);
        rd(12'hC82, 32'd7, 1'b0);
        rd(12'hC02, 32'd6, 1'b0);

        // Read-only and illegal addresses.
        wr(12'hC00, 32'd123);
        tick(1);                            // cycle lo = 4
        rd(12'hC00, 32'd4, 1'b0);
        rd(12'hC80, 32'd1, 1'b0);
        rd(12'h7C0, 32'h0, 1'b1);
        rd(12'h301, 32'h4000_1100, 1'b0);
        rd(12'hF14, 32'h0, 1'b0);
        wr(12'h301, 32'h0);
        tick(1);                            // cycle lo = 5
        wr(12'h340, 32'hDEAD_BEEF);
        rd(12'h301, 32'h4000_1100, 1'b0);
        rd(12'h340, 32'h0, 1'b0);           // same-cycle read sees old value
        tick(1);                            // cycle lo = 6
        wr(12'h000, 32'h0);
        rd(12'h340, 32'hDEAD_BEEF, 1'b0);
        rd(12'hC00, 32'd6, 1'b0);

        // One-cycle reset pulse with a write and a retire that must be lost.
        reset_i = 1'b1;
        wr(12'hB00, 32'd1234);
        bus.csrInstStep = 1'b1;
        tick(1);
        reset_i = 1'b0;
        wr(12'h000, 32'h0);
        bus.csrInstStep = 1'b0;
        rd(12'hC00, 32'h0, 1'b0);
        rd(12'hC80, 32'h0, 1'b0);
        rd(12'hC02, 32'h0, 1'b0);
        rd(12'hC82, 32'h0, 1'b0);
        rd(12'h340, 32'h0, 1'b0);
        rd(12'hC01, 32'h0, !TIME_ON);
        rd(12'h301, 32'h4000_1100, 1'b0);
        tick(1);
        rd(12'hC00, 32'd1, 1'b0);
        rd(12'hC02, 32'd0, 1'b0);

        tick(2);
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_csr_unit
